// File: rtl/y_fetch_unit.sv
// y_fetch_unit: instruction-fetch front end with a DEPTH-entry prefetch queue,
// single-outstanding req/gnt/rvalid memory handshake, branch/jump redirect,
// one-level interrupt entry (vector + EPC) and eret return.
module y_fetch_unit #(
  parameter int              AW      = 32,
  parameter int              DW      = 32,
  parameter int              DEPTH   = 4,
  parameter int              ILEN    = 4,
  parameter logic [AW-1:0]   INT_VEC = 'h80
) (
  input  logic          clk,
  input  logic          INT_n,
  input  logic [AW-1:0] entryPoint,
  input  logic          irq,
  input  logic          eret,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] ins,
  output logic [AW-1:0] ins_pc,
  output logic          ins_valid,
  input  logic          ins_ready,
  output logic [AW-1:0] epc,
  output logic          in_handler,
  output logic [31:0]   retired
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] r_q_ins [DEPTH];
  logic [AW-1:0] r_q_pc  [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_req_addr;
  logic          r_outstanding;
  logic          r_drop;
  logic [AW-1:0] r_epc;
  logic          r_in_handler;
  logic [31:0]   r_retired;

  logic w_irq_take;
  logic w_eret_take;
  logic w_redir_take;
  logic w_flush;
  logic w_valid;
  logic w_req;
  logic w_grant;
  logic w_resp;
  logic w_push;
  logic w_pop;

  // Flush arbitration: irq beats eret beats redirect; masked/ignored events fall through.
  assign w_irq_take   = irq & ~r_in_handler;
  assign w_eret_take  = ~w_irq_take & eret & r_in_handler;
  assign w_redir_take = ~w_irq_take & ~w_eret_take & redirect;
  assign w_flush      = w_irq_take | w_eret_take | w_redir_take;

  // Fetch only with room for the answer, nothing in flight, and out of reset.
  assign w_valid = (r_count != '0);
  assign w_req   = INT_n & ~w_flush & ~r_outstanding & (r_count < CW'(DEPTH));
  assign w_grant = w_req & imem_gnt;
  // A response that arrives in a flush cycle is stale and is discarded directly.
  assign w_resp  = imem_rvalid & r_outstanding;
  assign w_push  = w_resp & ~r_drop & ~w_flush;
  assign w_pop   = w_valid & ins_ready & ~w_flush;

  assign imem_req   = w_req;
  assign imem_addr  = r_pc;
  assign ins        = r_q_ins[r_rptr];
  assign ins_pc     = r_q_pc[r_rptr];
  assign ins_valid  = w_valid;
  assign epc        = r_epc;
  assign in_handler = r_in_handler;
  assign retired    = r_retired;

  // PC, handshake tracking, interrupt state and retire counter.
  always_ff @(posedge clk or negedge INT_n) begin
    if (!INT_n) begin
      r_pc          <= entryPoint;
      r_req_addr    <= '0;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
      r_epc         <= '0;
      r_in_handler  <= 1'b0;
      r_retired     <= '0;
    end else begin
      if (w_grant) begin
        r_pc          <= r_pc + AW'(ILEN);
        r_req_addr    <= r_pc;
        r_outstanding <= 1'b1;
      end
      if (w_resp) begin
        r_outstanding <= 1'b0;
        r_drop        <= 1'b0;
      end else if (w_flush && r_outstanding) begin
        r_drop <= 1'b1;
      end
      if (w_irq_take) begin
        r_epc        <= w_valid ? r_q_pc[r_rptr] : r_pc;
        r_pc         <= INT_VEC;
        r_in_handler <= 1'b1;
      end else if (w_eret_take) begin
        r_pc         <= r_epc;
        r_in_handler <= 1'b0;
      end else if (w_redir_take) begin
        r_pc <= redirect_pc;
      end
      if (w_pop) begin
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  // Prefetch queue storage and pointers; a flush simply empties it.
  always_ff @(posedge clk or negedge INT_n) begin
    if (!INT_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_ins[i] <= '0;
        r_q_pc[i]  <= '0;
      end
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_q_ins[r_wptr] <= imem_rdata;
        r_q_pc[r_wptr]  <= r_req_addr;
        r_wptr          <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_y_fetch_unit.sv
// Testbench for y_fetch_unit: transaction-level model plus directed scenarios.
module tb_y_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] VEC = 32'h80;

  logic        clk = 1'b0;
  logic        INT_n = 1'b0;
  logic [31:0] entryPoint = 32'd128;
  logic        irq = 1'b0, eret = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ins, ins_pc, epc;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic        in_handler;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  y_fetch_unit #(.AW(32), .DW(32), .DEPTH(DEPTH), .ILEN(4), .INT_VEC(VEC)) dut (
    .clk(clk), .INT_n(INT_n), .entryPoint(entryPoint), .irq(irq), .eret(eret),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .epc(epc), .in_handler(in_handler), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory: answers each grant after mem_lat cycles, in order.
  int          mem_lat = 1;
  bit          m_pend = 0;
  int          m_cnt = 0;
  logic [31:0] m_paddr = '0;
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (!INT_n) begin
      m_pend = 0;
    end else begin
      if (m_pend) begin
        if (m_cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mdata(m_paddr);
          m_pend      = 0;
        end else begin
          m_cnt--;
        end
      end
      if (imem_req && imem_gnt) begin
        m_pend  = 1;
        m_cnt   = mem_lat;
        m_paddr = imem_addr;
      end
    end
  end

  // Behavioural model: queue of fetched {data, addr} plus architectural state.
  typedef struct { logic [31:0] d; logic [31:0] p; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc = 32'd128, m_req_addr = '0, m_epc = '0, m_ret = '0;
  bit          m_out = 0, m_drop = 0, m_ih = 0;

  function automatic bit m_flush_now();
    bit fi, fe;
    fi = irq && !m_ih;
    fe = !fi && eret && m_ih;
    return fi || fe || (!fi && !fe && redirect);
  endfunction

  function automatic bit m_req_now();
    return !m_flush_now() && !m_out && (mq.size() < DEPTH);
  endfunction

  always @(posedge clk or negedge INT_n) begin : model
    bit fi, fe, fr, fl, rq, pp, push;
    logic [31:0] npc;
    if (!INT_n) begin
      m_pc = entryPoint; mq.delete(); m_out = 0; m_drop = 0;
      m_epc = '0; m_ih = 0; m_ret = '0;
    end else begin
      fi = irq && !m_ih;
      fe = !fi && eret && m_ih;
      fr = !fi && !fe && redirect;
      fl = fi || fe || fr;
      rq = m_req_now();
      pp = (mq.size() != 0) && ins_ready && !fl;
      push = 0;
      npc = m_pc;
      if (imem_rvalid && m_out) begin
        push = !m_drop && !fl;
        m_out = 0; m_drop = 0;
      end else if (fl && m_out) begin
        m_drop = 1;
      end
      if (fi) begin
        m_epc = (mq.size() != 0) ? mq[0].p : m_pc;
        npc = VEC; m_ih = 1;
      end else if (fe) begin
        npc = m_epc; m_ih = 0;
      end else if (fr) begin
        npc = redirect_pc;
      end
      if (pp) begin
        void'(mq.pop_front());
        m_ret = m_ret + 32'd1;
      end
      if (push) mq.push_back('{d: imem_rdata, p: m_req_addr});
      if (fl) mq.delete();
      if (rq && imem_gnt) begin
        m_req_addr = m_pc; m_out = 1; npc = m_pc + 32'd4;
      end
      m_pc = npc;
    end
  end

  // Every-cycle compare against the model (reset values while INT_n is low).
  always @(negedge clk) begin
    if (!INT_n) begin
      chk("rst_req", imem_req, 0);
      chk("rst_valid", ins_valid, 0);
      chk("rst_ins", ins, 0);
      chk("rst_ins_pc", ins_pc, 0);
      chk("rst_epc", epc, 0);
      chk("rst_in_handler", in_handler, 0);
      chk("rst_retired", retired, 0);
      chk("rst_addr", imem_addr, entryPoint);
    end else begin
      chk("cmp_req", imem_req, m_req_now());
      chk("cmp_addr", imem_addr, m_pc);
      chk("cmp_valid", ins_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("cmp_ins_pc", ins_pc, mq[0].p);
        chk("cmp_ins", ins, mq[0].d);
      end
      chk("cmp_epc", epc, m_epc);
      chk("cmp_in_handler", in_handler, m_ih);
      chk("cmp_retired", retired, m_ret);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic [31:0] exp_pc, input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (ins_valid) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting ins_valid, expected ins_pc %0h", nm, exp_pc);
    end else begin
      chk({nm, "_pc"}, ins_pc, exp_pc);
      chk({nm, "_ins"}, ins, mdata(exp_pc));
    end
  endtask

  task automatic wait_cond_req_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (ins_valid && imem_req) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_req: timeout, got 0 expected 1");
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_addr", imem_addr, 32'd128);
    chk("reset_valid", ins_valid, 0);
    tick(); INT_n = 1'b1;

    // Backpressure: queue fills to DEPTH, fetch stops at 144.
    repeat (20) @(negedge clk);
    chk("full_req", imem_req, 0);
    chk("full_addr", imem_addr, 32'd144);
    chk("full_head", ins_pc, 32'd128);
    chk("full_retired", retired, 0);

    tick(); ins_ready = 1'b1;
    wait_valid(32'd128, "seq0");
    wait_valid(32'd132, "seq1");
    wait_valid(32'd136, "seq2");
    wait_valid(32'd140, "seq3");
    wait_valid(32'd144, "seq4");
    @(negedge clk);
    chk("retired5", retired, 5);

    // Redirect while a request is in flight.
    tick(); ins_ready = 1'b0; mem_lat = 4;
    wait_cond_req_valid();
    tick(); redirect = 1'b1; redirect_pc = 32'h200;
    tick(); redirect = 1'b0;
    @(negedge clk);
    chk("redir_flushed", ins_valid, 0);
    wait_valid(32'h200, "redir");
    mem_lat = 1;

    // Interrupt entry, masked second irq, eret.
    tick(); redirect = 1'b1; redirect_pc = 32'h90;
    tick(); redirect = 1'b0;
    wait_valid(32'h90, "head90");
    tick(); irq = 1'b1;
    tick(); irq = 1'b0;
    @(negedge clk);
    chk("irq_epc", epc, 32'h90);
    chk("irq_ih", in_handler, 1);
    wait_valid(VEC, "irq_vec");
    tick(); irq = 1'b1;
    tick(); irq = 1'b0;
    @(negedge clk);
    chk("irq2_epc", epc, 32'h90);
    chk("irq2_head", ins_pc, VEC);
    chk("irq2_valid", ins_valid, 1);
    tick(); eret = 1'b1;
    tick(); eret = 1'b0;
    @(negedge clk);
    chk("eret_ih", in_handler, 0);
    wait_valid(32'h90, "eret");

    // All three flush sources at once: irq wins.
    tick(); irq = 1'b1; eret = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    tick(); irq = 1'b0; eret = 1'b0; redirect = 1'b0;
    @(negedge clk);
    chk("prio_ih", in_handler, 1);
    chk("prio_epc", epc, 32'h90);
    chk("prio_addr", imem_addr, VEC);
    wait_valid(VEC, "prio");
    // In handler, eret beats redirect.
    tick(); eret = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    tick(); eret = 1'b0; redirect = 1'b0;
    @(negedge clk);
    chk("prio2_ih", in_handler, 0);
    chk("prio2_addr", imem_addr, 32'h90);
    wait_valid(32'h90, "prio2");

    // PC wrap.
    tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); redirect = 1'b0; ins_ready = 1'b1;
    wait_valid(32'hFFFF_FFFC, "wrap_top");
    wait_valid(32'h0, "wrap_zero");

    // Reset mid-stream with a response in flight.
    mem_lat = 3;
    repeat (5) @(negedge clk);
    tick(); entryPoint = 32'h1000;
    #2 INT_n = 1'b0;
    #1;
    chk("mid_valid", ins_valid, 0);
    chk("mid_req", imem_req, 0);
    chk("mid_retired", retired, 0);
    chk("mid_ih", in_handler, 0);
    chk("mid_epc", epc, 0);
    chk("mid_addr", imem_addr, 32'h1000);
    repeat (3) @(negedge clk);
    tick(); INT_n = 1'b1;
    wait_valid(32'h1000, "post_rst0");
    wait_valid(32'h1004, "post_rst1");

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
